e2_sprite_render: RTL and testbench

Raster-domain pixel stage that sits directly downstream of the 16x16 raster scan generator. It consumes one (x, y) coordinate per cycle in row-major order, with x fastest. It produces a 4-bit colour per coordinate through a 2-stage pipeline, drawing a bordered rectangular sprite on a background. The sprite moves one pixel diagonally per completed frame and bounces off the screen edges.

---
 rtl/e2_sprite_render_if.sv | 23 ++
 rtl/e2_sprite_render.sv | 134 +++++++++++++
 tb/tb_e2_sprite_render.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/e2_sprite_render_if.sv
// Raster pixel bus: coordinate stream in, coloured pixel stream and sprite status out.
interface e2_sprite_render_if;
    logic       en;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] pixel;
    logic       pixel_valid;
    logic [3:0] x_out;
    logic [3:0] y_out;
    logic [3:0] sprite_x;
    logic [3:0] sprite_y;
    logic [7:0] frame_count;

    modport master (
        output en, x, y,
        input  pixel, pixel_valid, x_out, y_out, sprite_x, sprite_y, frame_count
    );

    modport slave (
        input  en, x, y,
        output pixel, pixel_valid, x_out, y_out, sprite_x, sprite_y, frame_count
    );
endinterface

// File: rtl/e2_sprite_render.sv
// Two-stage raster pixel stage drawing a bordered sprite that bounces one pixel
// diagonally per completed 16x16 frame.
module e2_sprite_render #(
    parameter int unsigned SPRITE_W      = 4,
    parameter int unsigned SPRITE_H      = 3,
    parameter logic [3:0]  FG_COLOUR     = 4'hF,
    parameter logic [3:0]  BORDER_COLOUR = 4'h8,
    parameter logic [3:0]  BG_COLOUR     = 4'h0
) (
    input logic               clk,
    input logic               reset,
    e2_sprite_render_if.slave bus
);
    localparam int unsigned XMAX  = 16 - SPRITE_W;
    localparam int unsigned YMAX  = 16 - SPRITE_H;
    localparam logic [4:0]  XMAX5 = 5'(XMAX);
    localparam logic [4:0]  YMAX5 = 5'(YMAX);
    localparam logic [4:0]  W_M1  = 5'(SPRITE_W - 1);
    localparam logic [4:0]  H_M1  = 5'(SPRITE_H - 1);

    logic       s1_v;
    logic [3:0] s1_x, s1_y;
    logic       dir_x, dir_y;
    logic [3:0] pixel_q, x_out_q, y_out_q, sprite_x_q, sprite_y_q;
    logic       pixel_valid_q;
    logic [7:0] frame_count_q;

    logic [4:0] sx5, sy5, px5, py5, x_right, y_bottom;
    logic       hit_c, border_c, frame_end_c;
    logic [3:0] colour_c;
    logic [3:0] nxt_sprite_x, nxt_sprite_y;
    logic       nxt_dir_x, nxt_dir_y;

    // Hit and border tests in 5 bits so the right/bottom edge cannot wrap.
    assign sx5      = {1'b0, s1_x};
    assign sy5      = {1'b0, s1_y};
    assign px5      = {1'b0, sprite_x_q};
    assign py5      = {1'b0, sprite_y_q};
    assign x_right  = px5 + W_M1;
    assign y_bottom = py5 + H_M1;

    always_comb begin
        hit_c    = (sx5 >= px5) && (sx5 <= x_right) && (sy5 >= py5) && (sy5 <= y_bottom);
        border_c = hit_c && ((sx5 == px5) || (sx5 == x_right) ||
                             (sy5 == py5) || (sy5 == y_bottom));
        colour_c = BG_COLOUR;
        if (border_c)
            colour_c = BORDER_COLOUR;
        else if (hit_c)
            colour_c = FG_COLOUR;
    end

    assign frame_end_c = s1_v && (s1_x == 4'hF) && (s1_y == 4'hF);

    // Bounce rule: reflect off an edge by reversing and stepping one pixel back.
    always_comb begin
        nxt_sprite_x = sprite_x_q;
        nxt_dir_x    = dir_x;
        nxt_sprite_y = sprite_y_q;
        nxt_dir_y    = dir_y;
        if (XMAX != 0) begin
            if (!dir_x) begin
                if (px5 < XMAX5) begin
                    nxt_sprite_x = sprite_x_q + 4'd1;
                end else begin
                    nxt_dir_x    = 1'b1;
                    nxt_sprite_x = sprite_x_q - 4'd1;
                end
            end else if (sprite_x_q != 4'd0) begin
                nxt_sprite_x = sprite_x_q - 4'd1;
            end else begin
                nxt_dir_x    = 1'b0;
                nxt_sprite_x = 4'd1;
            end
        end
        if (YMAX != 0) begin
            if (!dir_y) begin
                if (py5 < YMAX5) begin
                    nxt_sprite_y = sprite_y_q + 4'd1;
                end else begin
                    nxt_dir_y    = 1'b1;
                    nxt_sprite_y = sprite_y_q - 4'd1;
                end
            end else if (sprite_y_q != 4'd0) begin
                nxt_sprite_y = sprite_y_q - 4'd1;
            end else begin
                nxt_dir_y    = 1'b0;
                nxt_sprite_y = 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v          <= 1'b0;
            s1_x          <= 4'd0;
            s1_y          <= 4'd0;
            pixel_valid_q <= 1'b0;
            pixel_q       <= 4'd0;
            x_out_q       <= 4'd0;
            y_out_q       <= 4'd0;
            sprite_x_q    <= 4'd0;
            sprite_y_q    <= 4'd0;
            dir_x         <= 1'b0;
            dir_y         <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            s1_v          <= bus.en;
            s1_x          <= bus.x;
            s1_y          <= bus.y;
            pixel_valid_q <= s1_v;
            if (s1_v) begin
                pixel_q <= colour_c;
                x_out_q <= s1_x;
                y_out_q <= s1_y;
            end
            if (frame_end_c) begin
                frame_count_q <= frame_count_q + 8'd1;
                sprite_x_q    <= nxt_sprite_x;
                sprite_y_q    <= nxt_sprite_y;
                dir_x         <= nxt_dir_x;
                dir_y         <= nxt_dir_y;
            end
        end
    end

    assign bus.pixel       = pixel_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.x_out       = x_out_q;
    assign bus.y_out       = y_out_q;
    assign bus.sprite_x    = sprite_x_q;
    assign bus.sprite_y    = sprite_y_q;
    assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_e2_sprite_render.sv
// Directed bench for e2_sprite_render: default sprite plus a full-width, one-row sprite.
module tb_e2_sprite_render;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e2_sprite_render_if b1();
    e2_sprite_render_if b2();

    e2_sprite_render dut1 (.clk(clk), .reset(reset), .bus(b1));
    e2_sprite_render #(.SPRITE_W(16), .SPRITE_H(1)) dut2 (.clk(clk), .reset(reset), .bus(b2));

    typedef struct {
        int d;
        int fr;
        int x;
        int y;
        int exp;
    } vec_t;

    int passed = 0;
    int total  = 0;
    logic [3:0] img [2][4][16][16];
    int cap [2];
    vec_t vt [$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_in(input logic e, input int xx, input int yy);
        b1.en = e; b1.x = 4'(xx); b1.y = 4'(yy);
        b2.en = e; b2.x = 4'(xx); b2.y = 4'(yy);
    endtask

    task automatic flush(input int n);
        repeat (n) begin
            @(negedge clk);
            set_in(1'b0, 0, 0);
        end
    endtask

    // Full raster frame; gap_y = 4 inserts a 3-cycle en gap before x = 7 (frame 3 only).
    task automatic drive_frame(input int gap_y);
        int post;
        post = -1;
        for (int yy = 0; yy < 16; yy++) begin
            for (int xx = 0; xx < 16; xx++) begin
                if (yy == gap_y && xx == 7) begin
                    for (int g = 0; g < 3; g++) begin
                        @(negedge clk);
                        if (g == 1) begin
                            chk("gap_pre_valid", int'(b1.pixel_valid), 1);
                            chk("gap_pre_x", int'(b1.x_out), 6);
                            chk("gap_pre_pixel", int'(b1.pixel), 8);
                        end
                        if (g == 2) begin
                            chk("gap_low0", int'(b1.pixel_valid), 0);
                            chk("gap_hold_x0", int'(b1.x_out), 6);
                            chk("gap_hold_y0", int'(b1.y_out), 4);
                            chk("gap_hold_pix0", int'(b1.pixel), 8);
                            chk("gap_fc", int'(b1.frame_count), 3);
                            chk("gap_sx", int'(b1.sprite_x), 3);
                            chk("gap_sy", int'(b1.sprite_y), 3);
                        end
                        set_in(1'b0, 0, 0);
                    end
                    post = 0;
                end
                @(negedge clk);
                if (post == 0 || post == 1) begin
                    chk("gap_low", int'(b1.pixel_valid), 0);
                    chk("gap_hold_x", int'(b1.x_out), 6);
                    chk("gap_hold_pix", int'(b1.pixel), 8);
                end
                if (post == 2) begin
                    chk("gap_post_valid", int'(b1.pixel_valid), 1);
                    chk("gap_post_x", int'(b1.x_out), 7);
                end
                if (post >= 0 && post < 3) post++;
                set_in(1'b1, xx, yy);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (b1.pixel_valid) begin
            if (cap[0] < 4) img[0][cap[0]][b1.y_out][b1.x_out] = b1.pixel;
            if (b1.x_out == 4'hF && b1.y_out == 4'hF) cap[0]++;
        end
        if (b2.pixel_valid) begin
            if (cap[1] < 4) img[1][cap[1]][b2.y_out][b2.x_out] = b2.pixel;
            if (b2.x_out == 4'hF && b2.y_out == 4'hF) cap[1]++;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1, "timeout");
    end

    initial begin
        cap[0] = 0;
        cap[1] = 0;
        for (int d = 0; d < 2; d++)
            for (int f = 0; f < 4; f++)
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++)
                        img[d][f][r][c] = 4'h5;

        // Default sprite (4x3): frames 0..3 at (0,0),(1,1),(2,2),(3,3).
        vt.push_back('{0, 0, 0, 0, 8});  vt.push_back('{0, 0, 1, 1, 15});
        vt.push_back('{0, 0, 3, 2, 8});  vt.push_back('{0, 0, 4, 0, 0});
        vt.push_back('{0, 0, 0, 3, 0});  vt.push_back('{0, 0, 2, 1, 15});
        vt.push_back('{0, 0, 3, 1, 8});
        vt.push_back('{0, 1, 1, 1, 8});  vt.push_back('{0, 1, 0, 0, 0});
        vt.push_back('{0, 1, 2, 2, 15}); vt.push_back('{0, 1, 4, 3, 8});
        vt.push_back('{0, 1, 5, 2, 0});
        vt.push_back('{0, 2, 2, 2, 8});  vt.push_back('{0, 2, 3, 3, 15});
        vt.push_back('{0, 2, 5, 4, 8});  vt.push_back('{0, 2, 1, 2, 0});
        vt.push_back('{0, 3, 4, 4, 15}); vt.push_back('{0, 3, 6, 5, 8});
        vt.push_back('{0, 3, 2, 3, 0});  vt.push_back('{0, 3, 7, 4, 0});
        vt.push_back('{0, 3, 6, 4, 8});
        // Full-width one-row sprite: row k drawn in frame k.
        vt.push_back('{1, 0, 0, 0, 8});  vt.push_back('{1, 0, 15, 0, 8});
        vt.push_back('{1, 0, 0, 1, 0});
        vt.push_back('{1, 1, 0, 0, 0});  vt.push_back('{1, 1, 7, 1, 8});
        vt.push_back('{1, 1, 15, 1, 8}); vt.push_back('{1, 1, 3, 2, 0});
        vt.push_back('{1, 3, 0, 3, 8});  vt.push_back('{1, 3, 9, 3, 8});
        vt.push_back('{1, 3, 0, 2, 0});  vt.push_back('{1, 3, 15, 4, 0});

        reset = 1'b1;
        set_in(1'b0, 0, 0);
        #1;
        chk("rst_valid", int'(b1.pixel_valid), 0);
        chk("rst_pixel", int'(b1.pixel), 0);
        chk("rst_xout", int'(b1.x_out), 0);
        chk("rst_yout", int'(b1.y_out), 0);
        chk("rst_sx", int'(b1.sprite_x), 0);
        chk("rst_sy", int'(b1.sprite_y), 0);
        chk("rst_fc", int'(b1.frame_count), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        flush(3);
        chk("idle_valid", int'(b1.pixel_valid), 0);

        // Two-cycle latency on an aborted partial frame.
        @(negedge clk); set_in(1'b1, 0, 0);
        @(negedge clk);
        chk("lat_edge1_valid", int'(b1.pixel_valid), 0);
        set_in(1'b1, 1, 0);
        @(negedge clk);
        chk("lat_edge2_valid", int'(b1.pixel_valid), 1);
        chk("lat_pixel", int'(b1.pixel), 8);
        chk("lat_xout", int'(b1.x_out), 0);
        chk("lat_yout", int'(b1.y_out), 0);
        set_in(1'b0, 0, 0);
        flush(3);
        chk("partial_fc", int'(b1.frame_count), 0);
        chk("partial_sx", int'(b1.sprite_x), 0);

        // Frames 0 and 1 back to back.
        drive_frame(99);
        drive_frame(99);
        flush(2);
        chk("f2_fc", int'(b1.frame_count), 2);
        chk("f2_sx", int'(b1.sprite_x), 2);
        chk("f2_sy", int'(b1.sprite_y), 2);
        chk("f2_d2_sy", int'(b2.sprite_y), 2);

        // Frame end lands on the edge that registers (15,15).
        drive_frame(99);
        @(negedge clk);
        chk("fe_before_fc", int'(b1.frame_count), 2);
        chk("fe_before_sx", int'(b1.sprite_x), 2);
        set_in(1'b0, 0, 0);
        @(negedge clk);
        chk("fe_after_fc", int'(b1.frame_count), 3);
        chk("fe_after_sx", int'(b1.sprite_x), 3);
        chk("fe_after_sy", int'(b1.sprite_y), 3);
        chk("fe_d2_sx", int'(b2.sprite_x), 0);
        chk("fe_d2_sy", int'(b2.sprite_y), 3);
        flush(2);

        drive_frame(4);
        flush(2);
        chk("f4_fc", int'(b1.frame_count), 4);
        chk("f4_sx", int'(b1.sprite_x), 4);

        foreach (vt[i])
            chk($sformatf("img_d%0d_f%0d_(%0d,%0d)", vt[i].d, vt[i].fr, vt[i].x, vt[i].y),
                int'(img[vt[i].d][vt[i].fr][vt[i].y][vt[i].x]), vt[i].exp);
        for (int c = 0; c < 16; c++)
            chk($sformatf("d2_row1_x%0d", c), int'(img[1][1][1][c]), 8);

        // Bounce off the right and bottom edges.
        repeat (8) drive_frame(99);
        flush(2);
        chk("b12_sx", int'(b1.sprite_x), 12);
        chk("b12_sy", int'(b1.sprite_y), 12);
        drive_frame(99);
        flush(2);
        chk("b13_sx", int'(b1.sprite_x), 11);
        chk("b13_sy", int'(b1.sprite_y), 13);
        drive_frame(99);
        flush(2);
        chk("b14_sx", int'(b1.sprite_x), 10);
        chk("b14_sy", int'(b1.sprite_y), 12);
        chk("b14_fc", int'(b1.frame_count), 14);

        // Asynchronous reset in the middle of a row.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            set_in(1'b1, c, 0);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mrst_valid", int'(b1.pixel_valid), 0);
        chk("mrst_pixel", int'(b1.pixel), 0);
        chk("mrst_xout", int'(b1.x_out), 0);
        chk("mrst_sx", int'(b1.sprite_x), 0);
        chk("mrst_sy", int'(b1.sprite_y), 0);
        chk("mrst_fc", int'(b1.frame_count), 0);
        chk("mrst_d2_sy", int'(b2.sprite_y), 0);
        @(negedge clk);
        set_in(1'b0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", int'(b1.pixel_valid), 0);
        end

        // 256 frames from reset: frame_count wraps.
        for (int f = 0; f < 256; f++) begin
            drive_frame(99);
            if (f == 254) begin
                flush(2);
                chk("wrap_fc255", int'(b1.frame_count), 255);
            end
        end
        flush(2);
        chk("wrap_fc0", int'(b1.frame_count), 0);
        chk("wrap_sx", int'(b1.sprite_x), 8);
        chk("wrap_sy", int'(b1.sprite_y), 4);
        chk("wrap_d2_sx", int'(b2.sprite_x), 0);
        chk("wrap_d2_sy", int'(b2.sprite_y), 14);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
